// File: rtl/mdu_pkg.sv
// mdu_pkg: shared funct codes, FSM states and constants for the EX multiply/divide unit
package mdu_pkg;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: 64-bit shift-add multiply / restoring divide datapath, one step per cycle
module muldiv_iter_core #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        mode_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc,
  output logic        last
);
  localparam int CW = $clog2(ITER + 1);
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:0] sum;
  logic [33:0] diff;
  // mul keeps {partial product, multiplier}; div keeps {remainder, dividend/quotient}
  always_comb begin
    sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    diff = {1'b0, acc_q[63:31]} - {2'b0, opnd_q};
    acc_d = start ? {32'd0, a} : !step ? acc_q : !mode_div ? {sum, acc_q[31:1]} :
            diff[33] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    opnd_d = start ? b : opnd_q;
    cnt_d = start ? CW'(ITER - 1) : (step && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opnd_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opnd_q <= opnd_d;
      cnt_q <= cnt_d;
    end
  end
  assign acc = acc_q;
  assign last = cnt_q == '0;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage iterative multiply/divide unit owning HI/LO and driving stall
module ex_muldiv
  import mdu_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  funct_in,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, rs_q, rs_d;
  logic div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic acc_en, is_md, sgn, last;
  logic [31:0] ma, mb;
  logic [63:0] acc, prod;
  assign acc_en = state_q == IDLE && valid_in && !flush;
  assign is_md = funct_in[5:2] == 4'b0110;
  assign sgn = !funct_in[0];
  assign ma = (sgn && rs_val[31]) ? -rs_val : rs_val;
  assign mb = (sgn && rt_val[31]) ? -rt_val : rt_val;
  assign prod = qneg_q ? -acc : acc;
  muldiv_iter_core #(.ITER(ITER)) u_core (
    .clk(clk), .rst(rst), .start(acc_en && is_md), .step(state_q == RUN),
    .mode_div(div_q), .a(ma), .b(mb), .acc(acc), .last(last)
  );
  // acceptance, iteration sequencing and the sign-corrected HI/LO write in FIX
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    rs_d = rs_q;
    div_d = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    div0_d = div0_q;
    if (acc_en && is_md) begin
      state_d = RUN;
      rs_d = rs_val;
      div_d = funct_in[1];
      qneg_d = sgn && (rs_val[31] ^ rt_val[31]);
      rneg_d = sgn && rs_val[31];
      div0_d = rt_val == '0;
    end
    if (acc_en && funct_in == F_MTHI) hi_d = rs_val;
    if (acc_en && funct_in == F_MTLO) lo_d = rs_val;
    if (state_q == RUN && last) state_d = FIX;
    if (state_q == FIX) begin
      state_d = IDLE;
      if (!div_q) {hi_d, lo_d} = prod;
      else begin
        lo_d = div0_q ? DIV0_LO : qneg_q ? -acc[31:0] : acc[31:0];
        hi_d = div0_q ? rs_q : rneg_q ? -acc[63:32] : acc[63:32];
      end
    end
  end
  // FSM and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      rs_q <= '0;
      div_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      rs_q <= rs_d;
      div_q <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      div0_q <= div0_d;
    end
  end
  assign busy = state_q != IDLE;
  assign stall = valid_in && !flush && busy;
  assign result = !acc_en ? 32'd0 : funct_in == F_MFHI ? hi_q : funct_in == F_MFLO ? lo_q : 32'd0;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and reference-model checks of the EX multiply/divide unit
module tb_ex_muldiv;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, flush = 1'b0;
  logic [5:0] funct_in = 6'h0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic stall, busy;
  logic [31:0] result, hi, lo;
  int checks = 0, errors = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct_in(funct_in), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .stall(stall), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid_in = 1'b1;
    funct_in = f;
    rs_val = a;
    rt_val = b;
    #1;
  endtask

  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    present(f, a, b);
    chk({tag, "_accept_stall"}, {31'd0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] exp64;
    int n;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_result", result, 32'd0);

    present(6'h18, 32'hFFFFFFFE, 32'h00000003);
    tick();
    present(6'h10, 32'd0, 32'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    chk("mult_mfhi_stall_cycles", n, 32'd33);
    chk("mult_mfhi_result", result, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    tick();
    valid_in = 1'b0;

    do_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2);
    present(6'h12, 32'd0, 32'd0);
    chk("div_neg_mflo", result, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    tick();
    valid_in = 1'b0;

    do_op("divu_zero", 6'h1B, 32'd100, 32'd0);
    chk("divu_zero_lo", lo, 32'hFFFFFFFF);
    chk("divu_zero_hi", hi, 32'h00000064);

    do_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max_hi", hi, 32'hFFFFFFFE);
    chk("multu_max_lo", lo, 32'h00000001);
    present(6'h13, 32'd5, 32'd0);
    chk("mtlo_stall", {31'd0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("mtlo_lo", lo, 32'd5);
    chk("mtlo_hi", hi, 32'hFFFFFFFE);

    do_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    present(6'h20, 32'h12345678, 32'd7);
    tick();
    valid_in = 1'b0;
    chk("bad_funct_busy", {31'd0, busy}, 32'd0);
    chk("bad_funct_lo", lo, 32'h80000000);

    present(6'h18, 32'd1000, 32'd1000);
    tick();
    valid_in = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("midop_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    present(6'h10, 32'd0, 32'd0);
    chk("midrst_mfhi_stall", {31'd0, stall}, 32'd0);
    chk("midrst_mfhi_result", result, 32'd0);
    tick();
    valid_in = 1'b0;

    present(6'h11, 32'h00001234, 32'd0);
    tick();
    flush = 1'b1;
    present(6'h18, 32'd7, 32'd9);
    chk("flush_result", result, 32'd0);
    tick();
    valid_in = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'h00001234);
    chk("flush_lo", lo, 32'd0);

    for (int k = 0; k < 8; k++) begin
      a = $urandom;
      b = $urandom;
      if (k >= 4 && b == 32'd0) b = 32'd3;
      if (k == 5) b = {28'd0, b[3:0]} | 32'd1;
      case (k % 4)
        0: exp64 = 64'(longint'($signed(a)) * longint'($signed(b)));
        1: exp64 = {32'd0, a} * {32'd0, b};
        2: exp64 = {32'(int'($signed(a)) % int'($signed(b | 32'd1))), 32'(int'($signed(a)) / int'($signed(b | 32'd1)))};
        default: exp64 = {a % b, a / b};
      endcase
      if (k % 4 == 2) b = b | 32'd1;
      if (k % 4 >= 2 && b == 32'd0) exp64 = {a, 32'hFFFFFFFF};
      do_op("rand", 6'h18 + 6'(k % 4), a, b);
      chk($sformatf("rand%0d_hi a=%h b=%h", k, a, b), hi, exp64[63:32]);
      chk($sformatf("rand%0d_lo a=%h b=%h", k, a, b), lo, exp64[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the ID/EX register outputs (operands and funct) and owns the architectural HI/LO registers. It returns back-pressure (`stall`) to the hazard logic, which freezes PC, IF/ID and ID/EX and bubbles EX/MEM while an HI/LO-dependent instruction waits for an in-flight operation. MULT/DIV retire from the pipeline immediately; only later HI/LO users stall.

## Interface
Parameters:
- `ITER`, default 32: multiply/divide iteration cycles; one extra fixup cycle always follows.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `valid_in`  in  1: EX holds an MDU instruction (decoded from E control bits).
- `funct_in`  in  6: ID/EX funct.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- `rs_val`  in  32: forwarded rs operand (dividend / multiplicand / MTxx source).
- `rt_val`  in  32: forwarded rt operand (divisor / multiplier).
- `flush`  in  1: kill the EX instruction; qualifies `valid_in`.
- `stall`  out  1: combinational; `valid_in & ~flush & busy`.
- `busy`  out  1: an operation is in progress.
- `result`  out  32: HI for MFHI, LO for MFLO when accepted; 0 otherwise.
- `hi`, `lo`  out  32 each: architectural HI/LO.

## Operation
- States:
  - IDLE.
  - RUN: counter `ITER-1` down to 0.
  - FIX: sign correction and HI/LO write.
- Acceptance: in IDLE, when `valid_in & ~flush`. funct values not listed above are ignored, with no state change.
- MULT/MULTU/DIV/DIVU: latch operands; IDLE→RUN.
- MULT/MULTU:
  - Shift-add on magnitudes (MULT) or raw values (MULTU).
  - FIX negates the 64-bit product if operand signs differ.
  - {HI,LO} = product.
- DIV/DIVU:
  - Restoring division on magnitudes (DIV) or raw values (DIVU).
  - LO = quotient, truncated toward zero. HI = remainder, carrying the sign of the dividend.
- Divide by zero: LO = 0xFFFFFFFF, HI = `rs_val`. Still takes the full latency.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: in IDLE, write HI/LO at the accepting edge; no state change.
- MFHI/MFLO: in IDLE, `result` = current HI/LO, combinational.
- While busy, any MDU funct asserts `stall`. The instruction is held in EX and accepted in the first IDLE cycle.
- `flush` never aborts an in-progress operation.
- Reset (including mid-operation):
  - state IDLE, counter 0.
  - `hi` = `lo` = 0, `busy` = 0, `stall` = 0, `result` = 0.
  - The partial operation is discarded.

## Timing
- Acceptance edge E0 ends cycle c0. `busy` = 1 in cycles c1..c(ITER+1), which is 33 cycles by default.
- HI/LO update at the end of c(ITER+1). `busy` = 0 in c(ITER+2).
- MFHI presented in c1: stalls c1..c33, and `result` is valid in c34 (default `ITER`).
- MDU op arriving in c(ITER+2) or later: no stall.
- Back-to-back MULT in c1: stalls until c34, accepted at the end of c34.
- `valid_in` with `flush` = 1 in c0: no acceptance, HI/LO unchanged.
- `stall` has no registered delay. The hazard unit must not let `stall` depend on itself.

## Structure
- Shared package `mdu_pkg`:
  - funct localparams (`F_MULT` … `F_MTLO`).
  - state enum `{IDLE, RUN, FIX}`.
  - `DIV0_LO` = 32'hFFFFFFFF.
- One sub-module: `muldiv_iter_core`.
  - Contains the 64-bit accumulator/remainder datapath plus one shift-add/subtract step per cycle.
  - Has mode input mul/div, and start/step/last controls.
- The FSM, HI/LO, sign handling and `stall` live in `ex_muldiv`.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003, then MFHI in c1 → `stall` in c1..c33; in c34 `result` = 0xFFFFFFFF and LO = 0xFFFFFFFA.
- DIV with dividend −7 (0xFFFFFFF9) and divisor 2, then MFLO → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
- DIVU 100/0 → LO = 0xFFFFFFFF, HI = 0x00000064 after 33 busy cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Then MTLO 5 in c34 → LO = 5 and HI unchanged, no stall.
- MULT accepted, `rst` asserted in c10 → c11: `busy` = 0, `hi` = `lo` = 0. A following MFHI sees no stall and `result` = 0.
- MULT with `flush` = 1 → no `busy`, HI/LO unchanged. Random signed/unsigned operands are compared against a 64-bit reference model.
